fp_square_iter_ctrl: RTL



---
 rtl/fp_square_iter_ctrl_if.sv | 27 ++
 rtl/fp_square_iter_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fp_square_iter_ctrl_if.sv
// rtl/fp_square_iter_ctrl_if.sv - job handshake and result bus for the iterated FP squarer
interface fp_square_iter_ctrl_if #(
  parameter int inst_sig_width = 23,
  parameter int inst_exp_width = 8,
  parameter int CNT_WIDTH      = 4
);
  localparam int W = inst_sig_width + inst_exp_width;

  logic                 start;
  logic [W+3:0]         g_input;
  logic [W+3:0]         e_input;
  logic [CNT_WIDTH-1:0] k;
  logic                 busy;
  logic                 done;
  logic [W:0]           o;
  logic [7:0]           status;

  modport master (
    output start, g_input, e_input, k,
    input  busy, done, o, status
  );

  modport slave (
    input  start, g_input, e_input, k,
    output busy, done, o, status
  );
endinterface

// File: rtl/fp_square_iter_ctrl.sv
// rtl/fp_square_iter_ctrl.sv - computes a^(2^k) by iterating one FP squaring datapath, data-independent latency
module fp_square_dp #(
  parameter int inst_sig_width       = 23,
  parameter int inst_exp_width       = 8,
  parameter int inst_ieee_compliance = 0
) (
  input  logic [inst_sig_width+inst_exp_width:0] a,
  input  logic [2:0]                             rnd,
  output logic [inst_sig_width+inst_exp_width:0] z,
  output logic [7:0]                             status
);
  localparam int SW = inst_sig_width;
  localparam int EW = inst_exp_width;
  localparam int M  = SW + 1;
  localparam int XW = EW + 3;
  localparam logic [EW-1:0] EMAX = {EW{1'b1}};
  localparam logic [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX_S = XW'(EMAX);

  logic [EW-1:0]          ea;
  logic [SW-1:0]          fa;
  logic [2*M-1:0]         prod;
  logic                   hi;
  logic [SW-1:0]          mant;
  logic                   guard;
  logic                   sticky;
  logic                   inc;
  logic [SW:0]            rounded;
  logic signed [XW-1:0]   e_r;
  logic signed [XW-1:0]   e_f;

  assign ea   = a[SW+EW-1:SW];
  assign fa   = a[SW-1:0];
  assign prod = {1'b1, fa} * {1'b1, fa};
  assign hi   = prod[2*M-1];

  // Product of two [1,2) mantissas lies in [1,4): renormalise by one bit when >= 2.
  always_comb begin
    mant   = hi ? prod[2*M-2 -: SW] : prod[2*M-3 -: SW];
    guard  = hi ? prod[M-1] : prod[M-2];
    sticky = hi ? (|prod[M-2:0]) : (|prod[M-3:0]);
    e_r    = XW'({ea, 1'b0}) - BIAS + XW'(hi);
    case (rnd)
      3'd0:    inc = guard & (sticky | mant[0]);
      3'd2:    inc = guard | sticky;
      3'd4:    inc = guard;
      3'd5:    inc = guard | sticky;
      default: inc = 1'b0;
    endcase
    rounded = {1'b0, mant} + (SW+1)'(inc);
    e_f     = e_r + XW'(rounded[SW]);
  end

  // Denormal inputs are flushed to zero; NaN propagates only in IEEE mode.
  always_comb begin
    z      = '0;
    status = 8'h00;
    if (ea == EMAX && fa != '0) begin
      if (inst_ieee_compliance != 0) begin
        z      = {1'b0, EMAX, 1'b1, {(SW-1){1'b0}}};
        status = 8'h04;
      end else begin
        z      = {1'b0, EMAX, {SW{1'b0}}};
        status = 8'h02;
      end
    end else if (ea == EMAX) begin
      z      = {1'b0, EMAX, {SW{1'b0}}};
      status = 8'h02;
    end else if (ea == '0) begin
      z      = '0;
      status = 8'h01;
    end else if (e_f >= EMAX_S) begin
      if (rnd == 3'd1 || rnd == 3'd3) begin
        z      = {1'b0, EMAX - 1'b1, {SW{1'b1}}};
        status = 8'h30;
      end else begin
        z      = {1'b0, EMAX, {SW{1'b0}}};
        status = 8'h32;
      end
    end else if (e_f <= 0) begin
      z      = '0;
      status = 8'h29;
    end else begin
      z         = {1'b0, e_f[EW-1:0], rounded[SW-1:0]};
      status[5] = guard | sticky;
    end
  end
endmodule

module fp_square_iter_ctrl #(
  parameter int inst_sig_width       = 23,
  parameter int inst_exp_width       = 8,
  parameter int inst_ieee_compliance = 0,
  parameter int CNT_WIDTH            = 4
) (
  input logic clk,
  input logic rst,
  fp_square_iter_ctrl_if.slave bus
);
  localparam int W = inst_sig_width + inst_exp_width;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [W:0]           acc, acc_nxt;
  logic [2:0]           rnd_q, rnd_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [7:0]           stat_q, stat_nxt;
  logic [W:0]           o_q;
  logic [7:0]           status_q;
  logic [W:0]           z_dp;
  logic [7:0]           status_dp;

  fp_square_dp #(
    .inst_sig_width      (inst_sig_width),
    .inst_exp_width      (inst_exp_width),
    .inst_ieee_compliance(inst_ieee_compliance)
  ) u_dp (
    .a     (acc),
    .rnd   (rnd_q),
    .z     (z_dp),
    .status(status_dp)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rnd_nxt   = rnd_q;
    cnt_nxt   = cnt;
    stat_nxt  = stat_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt  = bus.g_input[W:0] ^ bus.e_input[W:0];
          rnd_nxt  = bus.g_input[W+3:W+1] ^ bus.e_input[W+3:W+1];
          stat_nxt = 8'h00;
          if (bus.k == '0) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = bus.k;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        acc_nxt  = z_dp;
        stat_nxt = stat_q | status_dp;
        cnt_nxt  = cnt - 1'b1;
        if (cnt == CNT_WIDTH'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      rnd_q    <= 3'd0;
      cnt      <= '0;
      stat_q   <= 8'h00;
      o_q      <= '0;
      status_q <= 8'h00;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      rnd_q  <= rnd_nxt;
      cnt    <= cnt_nxt;
      stat_q <= stat_nxt;
      // Result registers capture the value acc/stat_q take as DONE is entered.
      if (state_nxt == DONE && state != DONE) begin
        o_q      <= acc_nxt;
        status_q <= stat_nxt;
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.o      = o_q;
  assign bus.status = status_q;
endmodule
